// File: rtl/joy_serial_reader.sv
// joy_serial_reader
//   Polls chained serial-shift-register joystick adapters (shared CLK/LOAD,
//   single DATA line). Each frame: pulse joy_load low for one tick, then shift
//   N = NUM_PLAYERS*BITS_PER_PLAYER bits, one joy_clk period per bit. Data is
//   active-low and captured just before each rising joy_clk. After the frame,
//   each player's slice is debounced and committed to joy_out, and frame_done
//   pulses. An idle gap of POLL_GAP ticks separates frames.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   enable     in   polling allowed (checked only when leaving IDLE or GAP)
//   joy_data   in   serial data from adapter, active-low
//   joy_clk    out  shift clock, idles low
//   joy_load   out  parallel-load strobe, active-low
//   joy_out    out  16 bits per player, active-high buttons in the low bits
//   frame_done out  one-cycle pulse, coincident with the new joy_out value
//
// State table
//   S_IDLE   | not polling, waiting for enable
//   S_LOAD   | joy_load low for one tick
//   S_CLK_LO | joy_clk low for one tick, sample data on last cycle
//   S_CLK_HI | joy_clk high for one tick, advance bit index
//   S_COMMIT | one cycle, debounced result visible, frame_done high
//   S_GAP    | POLL_GAP idle ticks before the next frame

module joy_serial_reader #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV         = 24,
  parameter int POLL_GAP        = 16,
  parameter int DEBOUNCE        = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      joy_data,
  output logic                      joy_clk,
  output logic                      joy_load,
  output logic [NUM_PLAYERS*16-1:0] joy_out,
  output logic                      frame_done
);

  localparam int N  = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [2:0]    DB_TH    = 3'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLK_LO, S_CLK_HI, S_COMMIT, S_GAP
  } state_e;

  state_e                                          state_q, state_d;
  logic [DW-1:0]                                   div_q, div_d;
  logic [KW-1:0]                                   bit_q, bit_d;
  logic [GW-1:0]                                   gap_q, gap_d;
  logic [N-1:0]                                    cap_q, cap_d;
  logic [NUM_PLAYERS-1:0][BITS_PER_PLAYER-1:0]     prev_q, prev_d;
  logic [NUM_PLAYERS-1:0][2:0]                     cnt_q, cnt_d;
  logic [NUM_PLAYERS*16-1:0]                       out_q, out_d;
  logic                                            joy_clk_q, joy_clk_d;
  logic                                            joy_load_q, joy_load_d;
  logic                                            frame_done_q, frame_done_d;
  logic                                            tick;
  logic                                            commit;
  logic [BITS_PER_PLAYER-1:0]                      slice;
  logic [15:0]                                     ext;

  assign tick = (div_q == DIV_LAST);

  // Divider is held at zero in IDLE and COMMIT so LOAD and GAP start on a
  // fresh tick.
  always_comb begin
    div_d = div_q + 1'b1;
    if (state_q == S_IDLE || state_q == S_COMMIT || tick) div_d = '0;
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      cap_q        <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      cap_q        <= cap_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cap_d   = cap_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_LOAD;
      S_LOAD:   if (tick) begin
                  state_d = S_CLK_LO;
                  bit_d   = '0;
                end
      S_CLK_LO: if (tick) begin
                  cap_d[bit_q] = ~joy_data;
                  state_d      = S_CLK_HI;
                end
      S_CLK_HI: if (tick) begin
                  if (bit_q == K_LAST) begin
                    state_d = S_COMMIT;
                  end else begin
                    bit_d   = bit_q + 1'b1;
                    state_d = S_CLK_LO;
                  end
                end
      S_COMMIT: begin
                  if (POLL_GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LAST;
                  end else begin
                    state_d = enable ? S_LOAD : S_IDLE;
                  end
                end
      S_GAP:    if (tick) begin
                  if (gap_q == '0) state_d = enable ? S_LOAD : S_IDLE;
                  else             gap_d   = gap_q - 1'b1;
                end
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic. Registered outputs are computed from the next state so they
  // line up with state_q; the debounced result therefore appears in the same
  // cycle that state_q is COMMIT.
  always_comb begin
    joy_clk_d    = (state_d == S_CLK_HI);
    joy_load_d   = (state_d != S_LOAD);
    commit       = (state_d == S_COMMIT) && (state_q != S_COMMIT);
    frame_done_d = commit;
    out_d        = out_q;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    slice        = '0;
    ext          = '0;
    if (commit) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        slice = cap_q[p*BITS_PER_PLAYER +: BITS_PER_PLAYER];
        if (slice == prev_q[p])
          cnt_d[p] = (cnt_q[p] == 3'd7) ? 3'd7 : cnt_q[p] + 3'd1;
        else
          cnt_d[p] = 3'd1;
        prev_d[p] = slice;
        ext = '0;
        ext[BITS_PER_PLAYER-1:0] = slice;
        if (cnt_d[p] >= DB_TH) out_d[p*16 +: 16] = ext;
      end
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign joy_out    = out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_joy_serial_reader.sv
module tb_joy_serial_reader;

  logic        clk = 1'b0;
  logic [3:0]  rst = 4'hF;
  logic [3:0]  en = 4'h0;
  logic [3:0]  jdata;
  logic [3:0]  jclk, jload, fdone;
  logic [3:0]  jclk_prev = 4'h0;
  logic [31:0] out0, out1, out3;
  logic [63:0] out2;
  logic [63:0] pat [4];
  int          idx [4];
  logic [63:0] sb [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  joy_serial_reader #(.CLK_DIV(4), .POLL_GAP(0)) u0 (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .joy_data(jdata[0]),
    .joy_clk(jclk[0]), .joy_load(jload[0]), .joy_out(out0), .frame_done(fdone[0]));
  joy_serial_reader #(.CLK_DIV(4), .POLL_GAP(0), .DEBOUNCE(2)) u1 (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .joy_data(jdata[1]),
    .joy_clk(jclk[1]), .joy_load(jload[1]), .joy_out(out1), .frame_done(fdone[1]));
  joy_serial_reader #(.NUM_PLAYERS(4), .BITS_PER_PLAYER(8), .CLK_DIV(4), .POLL_GAP(0)) u2 (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .joy_data(jdata[2]),
    .joy_clk(jclk[2]), .joy_load(jload[2]), .joy_out(out2), .frame_done(fdone[2]));
  joy_serial_reader #(.CLK_DIV(2), .POLL_GAP(3)) u3 (
    .clk(clk), .reset(rst[3]), .enable(en[3]), .joy_data(jdata[3]),
    .joy_clk(jclk[3]), .joy_load(jload[3]), .joy_out(out3), .frame_done(fdone[3]));

  // Adapter model: load resets the shift position, each rising joy_clk
  // advances it; pat holds pressed buttons in serial order, driven active-low.
  initial for (int i = 0; i < 4; i++) begin pat[i] = '0; idx[i] = 0; end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      jclk_prev[i] <= jclk[i];
      if (!jload[i]) idx[i] <= 0;
      else if (jclk[i] && !jclk_prev[i]) idx[i] <= idx[i] + 1;
    end
  end

  always @* begin
    for (int i = 0; i < 4; i++) begin
      jdata[i] = 1'b1;
      if (idx[i] < 64) jdata[i] = ~pat[i][idx[i][5:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 4'hF; en = 4'h0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (jclk[i] !== 1'b0) begin errors++; $display("FAIL reset_jclk[%0d]: got %b expected 0", i, jclk[i]); end
      checks++;
      if (jload[i] !== 1'b1) begin errors++; $display("FAIL reset_jload[%0d]: got %b expected 1", i, jload[i]); end
      checks++;
      if (fdone[i] !== 1'b0) begin errors++; $display("FAIL reset_fdone[%0d]: got %b expected 0", i, fdone[i]); end
    end
    checks++;
    if ({out0, out1, out3} !== 96'h0 || out2 !== 64'h0) begin
      errors++; $display("FAIL reset_joy_out: got %h %h %h %h expected 0", out0, out1, out2, out3);
    end
    rst = 4'h0;
    repeat (5) step();
    checks++;
    if (jload !== 4'hF) begin errors++; $display("FAIL idle_jload: got %b expected 1111", jload); end
  endtask

  task automatic test_basic();
    int first_load_hi = -1, first_clk = -1, first_fd = -1, next_load = -1, overlap = 0, nfd = 0;
    logic [63:0] exp;
    pat[0] = {40'h0, 12'hF0F, 12'h0A5};
    sb.push_back(64'h0F0F_00A5);
    sb.push_back(64'h0F0F_00A5);
    en[0] = 1'b1;
    for (int t = 0; t < 400; t++) begin
      step();
      if (t == 200) en[0] = 1'b0;
      if (t == 0) begin
        checks++;
        if (jload[0] !== 1'b0) begin errors++; $display("FAIL basic_load_c0: got %b expected 0", jload[0]); end
      end
      if (jload[0] && first_load_hi < 0) first_load_hi = t;
      if (jclk[0] && first_clk < 0) first_clk = t;
      if (!jload[0] && jclk[0]) overlap++;
      if (first_fd >= 0 && t > first_fd && !jload[0] && next_load < 0) next_load = t;
      if (fdone[0]) begin
        nfd++;
        if (first_fd < 0) first_fd = t;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL basic_sb: unexpected frame_done at %0d", t); end
        else begin
          exp = sb.pop_front();
          if (out0 !== exp[31:0]) begin errors++; $display("FAIL basic_joy_out: got %h expected %h", out0, exp[31:0]); end
        end
      end
    end
    checks++;
    if (first_load_hi != 4) begin errors++; $display("FAIL basic_load_len: got %0d expected 4", first_load_hi); end
    checks++;
    if (first_clk != 8) begin errors++; $display("FAIL basic_clk_rise: got %0d expected 8", first_clk); end
    checks++;
    if (first_fd != 196) begin errors++; $display("FAIL basic_fd_cycle: got %0d expected 196", first_fd); end
    checks++;
    if (next_load != 197) begin errors++; $display("FAIL basic_next_load: got %0d expected 197", next_load); end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL basic_overlap: got %0d expected 0", overlap); end
    checks++;
    if (nfd != 2) begin errors++; $display("FAIL basic_nfd: got %0d expected 2", nfd); end
    sb.delete();
  endtask

  task automatic test_enable_drop();
    int nfd = 0, fd_t = -1, loads_after = 0;
    logic [63:0] exp;
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    pat[0] = {40'h0, 12'h456, 12'h123};
    sb.push_back(64'h0456_0123);
    en[0] = 1'b1;
    for (int t = 0; t < 1200; t++) begin
      step();
      if (t == 84) en[0] = 1'b0;
      if (t >= 197 && !jload[0]) loads_after++;
      if (fdone[0]) begin
        nfd++;
        fd_t = t;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL drop_sb: unexpected frame_done at %0d", t); end
        else begin
          exp = sb.pop_front();
          if (out0 !== exp[31:0]) begin errors++; $display("FAIL drop_joy_out: got %h expected %h", out0, exp[31:0]); end
        end
      end
    end
    checks++;
    if (nfd != 1) begin errors++; $display("FAIL drop_nfd: got %0d expected 1", nfd); end
    checks++;
    if (fd_t != 196) begin errors++; $display("FAIL drop_fd_cycle: got %0d expected 196", fd_t); end
    checks++;
    if (loads_after != 0) begin errors++; $display("FAIL drop_idle_loads: got %0d expected 0", loads_after); end
    en[0] = 1'b1;
    step();
    checks++;
    if (jload[0] !== 1'b0) begin errors++; $display("FAIL drop_reenable: got %b expected 0", jload[0]); end
    en[0] = 1'b0;
    repeat (250) step();
    sb.delete();
  endtask

  task automatic test_reset_mid_frame();
    int nfd = 0, bad_load = 0, bad_out = 0;
    logic [63:0] exp;
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    pat[0] = 64'h0FFF;
    sb.push_back(64'h0000_0FFF);
    en[0] = 1'b1;
    for (int t = 0; t <= 321; t++) begin
      step();
      if (fdone[0]) begin
        nfd++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rmid_sb: unexpected frame_done at %0d", t); end
        else begin
          exp = sb.pop_front();
          if (out0 !== exp[31:0]) begin errors++; $display("FAIL rmid_first: got %h expected %h", out0, exp[31:0]); end
        end
      end
    end
    checks++;
    if (nfd != 1) begin errors++; $display("FAIL rmid_nfd: got %0d expected 1", nfd); end
    rst[0] = 1'b1; en[0] = 1'b0;
    step();
    checks++;
    if ({out0, jclk[0], jload[0], fdone[0]} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rmid_after_reset: got out=%h clk=%b load=%b fd=%b expected out=0 clk=0 load=1 fd=0",
               out0, jclk[0], jload[0], fdone[0]);
    end
    rst[0] = 1'b0;
    nfd = 0;
    for (int t = 0; t < 500; t++) begin
      step();
      if (fdone[0]) nfd++;
      if (!jload[0]) bad_load++;
      if (out0 !== 32'h0) bad_out++;
    end
    checks++;
    if (nfd != 0 || bad_load != 0 || bad_out != 0) begin
      errors++; $display("FAIL rmid_no_commit: got fd=%0d loads=%0d nonzero=%0d expected 0 0 0", nfd, bad_load, bad_out);
    end
    en[0] = 1'b1;
    step();
    checks++;
    if (jload[0] !== 1'b0) begin errors++; $display("FAIL rmid_idle_exit: got %b expected 0", jload[0]); end
    en[0] = 1'b0;
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    sb.delete();
  endtask

  task automatic test_debounce();
    int n = 0;
    logic [63:0] exp;
    pat[1] = 64'h001;
    sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h2); sb.push_back(64'h2);
    en[1] = 1'b1;
    for (int t = 0; t < 1000 && n < 4; t++) begin
      step();
      if (fdone[1]) begin
        n++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL deb_sb: unexpected frame_done"); end
        else begin
          exp = sb.pop_front();
          if (out1 !== exp[31:0]) begin errors++; $display("FAIL deb_frame%0d: got %h expected %h", n, out1, exp[31:0]); end
        end
        if (n == 1 || n == 2) pat[1] = 64'h002;
        if (n == 3) pat[1] = 64'h003;
        if (n == 4) en[1] = 1'b0;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL deb_frames: got %0d expected 4", n); end
    sb.delete();
  endtask

  task automatic test_geometry();
    int fd_t = -1;
    logic [63:0] exp;
    pat[2] = 64'hFFFF_FFFF;
    sb.push_back(64'h00FF_00FF_00FF_00FF);
    en[2] = 1'b1;
    for (int t = 0; t < 400 && fd_t < 0; t++) begin
      step();
      if (fdone[2]) begin
        fd_t = t;
        en[2] = 1'b0;
        checks++;
        exp = sb.pop_front();
        if (out2 !== exp) begin errors++; $display("FAIL geo_joy_out: got %h expected %h", out2, exp); end
      end
    end
    checks++;
    if (fd_t != 260) begin errors++; $display("FAIL geo_fd_cycle: got %0d expected 260", fd_t); end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int loads [$];
    int first_fd = -1, nfd = 0;
    logic prev_load = 1'b1;
    logic [63:0] exp;
    pat[3] = {40'h0, 12'h5A5, 12'h3C3};
    repeat (3) sb.push_back(64'h05A5_03C3);
    en[3] = 1'b1;
    for (int t = 0; t <= 320; t++) begin
      step();
      if (!jload[3] && prev_load) loads.push_back(t);
      prev_load = jload[3];
      if (fdone[3]) begin
        nfd++;
        if (first_fd < 0) first_fd = t;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL gap_sb: unexpected frame_done at %0d", t); end
        else begin
          exp = sb.pop_front();
          if (out3 !== exp[31:0]) begin errors++; $display("FAIL gap_joy_out: got %h expected %h", out3, exp[31:0]); end
        end
      end
    end
    en[3] = 1'b0;
    checks++;
    if (first_fd != 98) begin errors++; $display("FAIL gap_fd_cycle: got %0d expected 98", first_fd); end
    checks++;
    if (nfd != 3) begin errors++; $display("FAIL gap_nfd: got %0d expected 3", nfd); end
    checks++;
    if (loads.size() != 4) begin errors++; $display("FAIL gap_nloads: got %0d expected 4", loads.size()); end
    else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (loads[i] - loads[i-1] != 105) begin
          errors++; $display("FAIL gap_period%0d: got %0d expected 105", i, loads[i] - loads[i-1]);
        end
      end
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_drop();
    test_reset_mid_frame();
    test_debounce();
    test_geometry();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
